// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end: datapath width, the filler
// instruction used for faulting or flushed entries, fetch exception cause
// codes, the fetch state encoding and the IF/ID entry field widths.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN       = 64;
   localparam int INSN_W     = 32;
   localparam int EXC_CODE_W = 4;

   // ADDI x0, x0, 0
   localparam logic [INSN_W-1:0] NOP_INSN = 32'h00000013;

   localparam logic [EXC_CODE_W-1:0] EXC_INSN_MISALIGNED   = 4'd0;
   localparam logic [EXC_CODE_W-1:0] EXC_INSN_ACCESS_FAULT = 4'd1;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID output entry register with a valid/ready handshake toward decode.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture the in_* entry and mark it valid
//   flush           : drop the held entry (takes priority over load)
//   ready           : decode accepts the held entry this cycle
//   in_*            : entry to capture (instr, pc, exception fields)
//   valid, instr... : held entry presented to decode
// -----------------------------------------------------------------------------
module if_id_reg #(
   parameter int                         XLEN     = cpu_pkg::XLEN,
   parameter logic [cpu_pkg::INSN_W-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             load,
   input  logic                             flush,
   input  logic                             ready,
   input  logic [cpu_pkg::INSN_W-1:0]       in_instr,
   input  logic [XLEN-1:0]                  in_pc,
   input  logic                             in_exc_en,
   input  logic [cpu_pkg::EXC_CODE_W-1:0]   in_exc_code,
   input  logic [XLEN-1:0]                  in_exc_val,
   output logic                             valid,
   output logic [cpu_pkg::INSN_W-1:0]       instr,
   output logic [XLEN-1:0]                  pc,
   output logic                             exc_en,
   output logic [cpu_pkg::EXC_CODE_W-1:0]   exc_code,
   output logic [XLEN-1:0]                  exc_val
);

   import cpu_pkg::*;

   // Flush only clears valid; the payload fields are don't-care while
   // invalid, so they keep their last value. A handshake with no refill
   // empties the register.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         instr    <= NOP_INSN;
         pc       <= '0;
         exc_en   <= 1'b0;
         exc_code <= '0;
         exc_val  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= in_instr;
         pc       <= in_pc;
         exc_en   <= in_exc_en;
         exc_code <= in_exc_code;
         exc_val  <= in_exc_val;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch initiator. Owns the PC, drives the combinational
// instruction memory and registers each fetched word into the IF/ID entry.
// Halts after issuing a fetch exception until a redirect arrives.
//   clk, rst        : clock, synchronous active-high reset
//   imem_addr       : fetch address (the pc register)
//   imem_instr      : instruction word for imem_addr, same cycle
//   imem_exc_*      : memory access fault flag, cause and value
//   redirect_en/pc  : flush the pipeline entry and restart at redirect_pc
//   out_valid/ready : IF/ID handshake toward decode
//   out_*           : IF/ID entry (instr, pc, exception fields)
//   fault_halt      : high while halted in FAULT
// -----------------------------------------------------------------------------
module ifetch_unit #(
   parameter int                         XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0]            RESET_PC = '0,
   parameter logic [cpu_pkg::INSN_W-1:0] NOP_INSN = cpu_pkg::NOP_INSN
) (
   input  logic                             clk,
   input  logic                             rst,
   output logic [XLEN-1:0]                  imem_addr,
   input  logic [cpu_pkg::INSN_W-1:0]       imem_instr,
   input  logic                             imem_exc_en,
   input  logic [cpu_pkg::EXC_CODE_W-1:0]   imem_exc_code,
   input  logic [XLEN-1:0]                  imem_exc_val,
   input  logic                             redirect_en,
   input  logic [XLEN-1:0]                  redirect_pc,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [cpu_pkg::INSN_W-1:0]       out_instr,
   output logic [XLEN-1:0]                  out_pc,
   output logic                             out_exc_en,
   output logic [cpu_pkg::EXC_CODE_W-1:0]   out_exc_code,
   output logic [XLEN-1:0]                  out_exc_val,
   output logic                             fault_halt
);

   import cpu_pkg::*;

   fetch_state_e            state;
   logic [XLEN-1:0]         pc;
   logic                    adv;
   logic                    load;
   logic                    fault_now;
   logic [INSN_W-1:0]       ld_instr;
   logic                    ld_exc_en;
   logic [EXC_CODE_W-1:0]   ld_code;
   logic [XLEN-1:0]         ld_val;

   assign imem_addr = pc;
   assign adv       = (state == RUN) && (!out_valid || out_ready);
   assign load      = adv && !redirect_en;

   // Build the entry for the current pc. A misaligned pc is checked first
   // and ignores the memory response entirely; otherwise a memory access
   // fault replaces the word with a NOP and forwards the memory's cause.
   always_comb begin
      ld_instr  = imem_instr;
      ld_exc_en = 1'b0;
      ld_code   = '0;
      ld_val    = '0;
      fault_now = 1'b0;
      if (pc[1:0] != 2'b00) begin
         ld_instr  = NOP_INSN;
         ld_exc_en = 1'b1;
         ld_code   = EXC_INSN_MISALIGNED;
         ld_val    = pc;
         fault_now = 1'b1;
      end else if (imem_exc_en) begin
         ld_instr  = NOP_INSN;
         ld_exc_en = 1'b1;
         ld_code   = imem_exc_code;
         ld_val    = imem_exc_val;
         fault_now = 1'b1;
      end
   end

   // PC and fetch state. A redirect always wins and returns to RUN. On a
   // faulting fetch the pc is frozen at the faulting address and the unit
   // halts, so the memory flag is only ever sampled once per fault.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         state      <= RUN;
         fault_halt <= 1'b0;
      end else if (redirect_en) begin
         pc         <= redirect_pc;
         state      <= RUN;
         fault_halt <= 1'b0;
      end else if (adv) begin
         if (fault_now) begin
            state      <= FAULT;
            fault_halt <= 1'b1;
         end else begin
            pc <= pc + XLEN'(4);
         end
      end
   end

   if_id_reg #(
      .XLEN     (XLEN),
      .NOP_INSN (NOP_INSN)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .flush       (redirect_en),
      .ready       (out_ready),
      .in_instr    (ld_instr),
      .in_pc       (pc),
      .in_exc_en   (ld_exc_en),
      .in_exc_code (ld_code),
      .in_exc_val  (ld_val),
      .valid       (out_valid),
      .instr       (out_instr),
      .pc          (out_pc),
      .exc_en      (out_exc_en),
      .exc_code    (out_exc_code),
      .exc_val     (out_exc_val)
   );

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator: owns the PC, drives the combinational instruction memory's address port and registers the returned word, PC and fetch fault into an IF/ID output register.
- Output register uses a valid/ready handshake toward decode.
- Services redirects from branch resolution and trap logic.
- Stops fetching after a fetch fault until a redirect (trap vector) arrives.

Parameters:
- XLEN, 64, PC and address width.
- RESET_PC, 64'h0, PC loaded on reset.
- NOP_INSN, 32'h00000013, instruction word presented with faulting or flushed entries.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_addr  out  XLEN  fetch address to instruction memory (equals pc register).
- imem_instr  in  32  instruction word returned combinationally in the same cycle.
- imem_exc_en  in  1  memory access-fault flag for imem_addr.
- imem_exc_code  in  4  memory fault cause (1 = instruction access fault).
- imem_exc_val  in  XLEN  memory fault value (bad PC).
- redirect_en  in  1  flush and load new PC (branch or trap).
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  IF/ID entry valid.
- out_ready  in  1  decode accepts entry.
- out_instr  out  32  fetched instruction.
- out_pc  out  XLEN  PC of entry.
- out_exc_en  out  1  entry carries a fetch exception.
- out_exc_code  out  4  cause: 0 = misaligned, 1 = access fault.
- out_exc_val  out  XLEN  faulting PC.
- fault_halt  out  1  high while in the FAULT state.

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC; out_valid=0; out_instr=NOP_INSN; out_pc=0; out_exc_en=0; out_exc_code=0; out_exc_val=0; state=RUN; fault_halt=0. Reset mid-operation discards any held entry.
- imem_addr = pc, combinational from the register.
- Advance condition: adv = state==RUN && (!out_valid || out_ready).
- States:
  - RUN: fetching.
  - FAULT: an exception entry has been issued; no further fetch; pc holds its value.
- Normal fetch (adv, no redirect, no fault):
  - Output register loads {imem_instr, pc, exc_en=0} with out_valid=1.
  - pc <= pc+4 (wrap modulo 2^XLEN).
  - Throughput: one instruction per cycle. Latency: address to out_valid is 1 cycle.
- Stall (out_valid && !out_ready): output register and pc hold; imem_addr is stable.
- Consume without refill (out_ready && !adv, i.e. in FAULT): out_valid <= 0 on handshake.
- Misalign (adv && pc[1:0]!=0):
  - Entry = {NOP_INSN, pc, exc_en=1, code=0, val=pc}.
  - Memory response is ignored; state -> FAULT.
- Access fault (adv && pc aligned && imem_exc_en):
  - Entry = {NOP_INSN, pc, exc_en=1, code=imem_exc_code, val=imem_exc_val}.
  - state -> FAULT.
  - Latched on the first cycle seen; memory deasserting exc_en afterwards has no effect.
- Misalign has priority over access fault.
- FAULT: fault_halt=1. The entry stays until accepted, then out_valid=0. Only a redirect leaves FAULT.
- Redirect (redirect_en=1), highest priority below rst:
  - pc <= redirect_pc; out_valid <= 0 (flush, regardless of out_ready); state -> RUN.
  - The memory response in that cycle is discarded.
  - First fetch from the target appears on out_valid 1 cycle after the redirect cycle, i.e. a 1-bubble penalty.
- Simultaneous redirect and handshake: the handshake is considered completed and the flush wins; no duplicate entry.
- While out_valid=1, out_* fields never change unless there is a handshake, redirect or rst.

Decomposition:
- Shared package (cpu_pkg):
  - XLEN.
  - NOP_INSN.
  - Exception cause constants EXC_INSN_MISALIGNED=0, EXC_INSN_ACCESS_FAULT=1.
  - Fetch state encoding {RUN, FAULT}.
  - IF/ID entry field widths.
- One natural sub-module: if_id_reg, the output entry register with valid/ready, load and flush. The PC, state machine and fault selection stay in ifetch_unit.

Test Plan:
- Reset then run with out_ready=1 and imem returning distinct words -> out_pc sequence 0x0, 0x4, 0x8 on consecutive cycles, out_valid=1 from cycle 1, out_exc_en=0.
- Hold out_ready=0 for 3 cycles at pc 0x8 -> out_pc=0x8 and out_instr constant, imem_addr=0xC stable; release -> 0xC next cycle, no drop or duplicate.
- redirect_en with redirect_pc=0x100 while entry 0x10 is pending and out_ready=0 -> out_valid=0 next cycle, then out_pc=0x100; entry 0x10 is never accepted.
- imem_exc_en=1, code=1 at pc=0x2000 -> entry {NOP_INSN, pc=0x2000, exc_en=1, code=1, val=0x2000}; fault_halt=1; after accept out_valid=0 and imem_addr holds 0x2000; redirect to 0x80 resumes fetch.
- redirect_pc=0x102 -> entry exc_en=1, code=0, val=0x102 even if imem_exc_en=1; state FAULT.
- Assert rst for 1 cycle during a stall in FAULT -> all outputs at reset values, pc=RESET_PC, fault_halt=0, fetching resumes the next cycle.
